// File: rtl/keyprt_cmd_sequencer.sv
`timescale 1ns/1ps
// Host-side sequencer for the MCS4_SYS key/printer command port: key strokes and printer FIFO pops.
// Optional expected-response checking (REQ_EXP/ERR) is built when KEYPRT_SEQ_EXPECT_EN is defined.
module keyprt_cmd_sequencer #(
    parameter int PRESS_CYC   = 50000,
    parameter int RELEASE_CYC = 50000,
    parameter int POP_LAT     = 4,
    parameter int POP_HOLD    = 10000,
    parameter int POP_REL     = 10000,
    parameter int CNT_W       = 20
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_OP,
    input  logic [7:0]  REQ_KEY,
    output logic [31:0] PORT_KEYPRT_CMD,
    input  logic [31:0] PORT_KEYPRT_RES,
    output logic        RSP_VALID,
    output logic [31:0] RSP_DATA,
    output logic        RSP_EMPTY,
    output logic        BUSY
`ifdef KEYPRT_SEQ_EXPECT_EN
    ,
    input  logic [31:0] REQ_EXP,
    output logic        ERR
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS,
        ST_REL_KEY,
        ST_POP,
        ST_REL_POP
    } state_t;

    localparam logic [31:0] CMD_IDLE = 32'h8000_0000;
    localparam logic [31:0] CMD_POP  = 32'h8000_8000;

    // Timer reload values are interval-1; an interval of 0 behaves like 1.
    localparam logic [CNT_W-1:0] LD_PRESS   = CNT_W'((PRESS_CYC   > 0) ? PRESS_CYC   - 1 : 0);
    localparam logic [CNT_W-1:0] LD_RELEASE = CNT_W'((RELEASE_CYC > 0) ? RELEASE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'((POP_HOLD    > 0) ? POP_HOLD    - 1 : 0);
    localparam logic [CNT_W-1:0] LD_POP_REL = CNT_W'((POP_REL     > 0) ? POP_REL     - 1 : 0);
    localparam logic [CNT_W-1:0] LD_CAPT    = CNT_W'(POP_HOLD - POP_LAT);

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic [31:0]      r_cmd;
    logic             r_ready;
    logic             r_busy;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_data;
    logic             r_rsp_empty;

    logic w_handshake;
    logic w_capture;
    logic w_timer_zero;

    assign w_handshake  = (r_state == ST_IDLE) && REQ_VALID && r_ready;
    // The capture edge ends the POP_LAT-th cycle that the pop command has been on the port.
    assign w_capture    = (r_state == ST_POP) && (r_timer == LD_CAPT);
    assign w_timer_zero = (r_timer == '0);

    // NOTE: state uses non-blocking assignments and an asynchronous reset so every output is a clean flop.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_cmd       <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_empty <= 1'b0;
        end else begin
            // NOTE: default first so the response strobe is a single-cycle pulse.
            r_rsp_valid <= 1'b0;

            if (w_capture) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= PORT_KEYPRT_RES;
                r_rsp_empty <= ~PORT_KEYPRT_RES[0];
            end

            case (r_state)
                ST_IDLE: begin
                    r_cmd   <= CMD_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    if (w_handshake) begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (REQ_OP) begin
                            r_state <= ST_POP;
                            r_cmd   <= CMD_POP;
                            r_timer <= LD_HOLD;
                        end else begin
                            r_state <= ST_PRESS;
                            r_cmd   <= CMD_IDLE | {24'b0, REQ_KEY};
                            r_timer <= LD_PRESS;
                        end
                    end
                end

                ST_PRESS: begin
                    if (w_timer_zero) begin
                        r_state <= ST_REL_KEY;
                        r_cmd   <= CMD_IDLE;
                        r_timer <= LD_RELEASE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                ST_POP: begin
                    if (w_timer_zero) begin
                        r_state <= ST_REL_POP;
                        r_cmd   <= CMD_IDLE;
                        r_timer <= LD_POP_REL;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                ST_REL_KEY, ST_REL_POP: begin
                    // Ready rises on the completing edge so the next request sees it one cycle later.
                    if (w_timer_zero) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cmd   <= CMD_IDLE;
                    r_timer <= '0;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef KEYPRT_SEQ_EXPECT_EN
    logic [31:0] r_exp;
    logic        r_err;

    // The expectation is latched with the pop request; the error flag is sticky until reset.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_exp <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_handshake && REQ_OP) begin
                r_exp <= REQ_EXP;
            end
            if (w_capture && (PORT_KEYPRT_RES != r_exp)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ERR = r_err;
`endif

    assign REQ_READY       = r_ready;
    assign BUSY            = r_busy;
    assign PORT_KEYPRT_CMD = r_cmd;
    assign RSP_VALID       = r_rsp_valid;
    assign RSP_DATA        = r_rsp_data;
    assign RSP_EMPTY       = r_rsp_empty;

endmodule

// File: tb/tb_keyprt_cmd_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for keyprt_cmd_sequencer: directed and random operations against a cycle-indexed model.
module tb_keyprt_cmd_sequencer;

    localparam int P  = 8;
    localparam int R  = 8;
    localparam int L  = 4;
    localparam int H  = 10;
    localparam int RP = 6;
    localparam int NR = 14;
    localparam logic [31:0] IDLE_CMD = 32'h8000_0000;
    localparam logic [31:0] POP_CMD  = 32'h8000_8000;

    logic        CLK = 1'b0;
    logic        RES;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_OP;
    logic [7:0]  REQ_KEY;
    logic [31:0] PORT_KEYPRT_CMD;
    logic [31:0] PORT_KEYPRT_RES;
    logic        RSP_VALID;
    logic [31:0] RSP_DATA;
    logic        RSP_EMPTY;
    logic        BUSY;
    logic [31:0] REQ_EXP;
    logic        ERR;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_rsp_data;
    logic        m_rsp_empty;
    logic        m_err;

    logic        r_op  [NR];
    logic [7:0]  r_key [NR];
    logic [31:0] r_res [NR];
    logic [31:0] r_exp [NR];
    logic        r_hold[NR];

    keyprt_cmd_sequencer #(
        .PRESS_CYC  (P),
        .RELEASE_CYC(R),
        .POP_LAT    (L),
        .POP_HOLD   (H),
        .POP_REL    (RP),
        .CNT_W      (20)
    ) dut (
        .CLK            (CLK),
        .RES            (RES),
        .REQ_VALID      (REQ_VALID),
        .REQ_READY      (REQ_READY),
        .REQ_OP         (REQ_OP),
        .REQ_KEY        (REQ_KEY),
        .PORT_KEYPRT_CMD(PORT_KEYPRT_CMD),
        .PORT_KEYPRT_RES(PORT_KEYPRT_RES),
        .RSP_VALID      (RSP_VALID),
        .RSP_DATA       (RSP_DATA),
        .RSP_EMPTY      (RSP_EMPTY),
`ifdef KEYPRT_SEQ_EXPECT_EN
        .REQ_EXP        (REQ_EXP),
        .ERR            (ERR),
`endif
        .BUSY           (BUSY)
    );

`ifndef KEYPRT_SEQ_EXPECT_EN
    assign ERR = 1'b0;
`endif

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_err();
`ifdef KEYPRT_SEQ_EXPECT_EN
        chk("err", 32'(ERR), 32'(m_err));
`endif
    endtask

    // Expected behaviour by cycle index k after the accepting edge (k = total+1 is the next idle cycle).
    task automatic run_op(input logic op, input logic [7:0] key, input logic [31:0] res_val,
                          input logic [31:0] exp_val, input logic hold, input logic nop,
                          input logic [7:0] nkey, input logic [31:0] nexp);
        int          total;
        logic [31:0] exp_cmd;
        total = op ? (H + RP) : (P + R);
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                REQ_VALID = hold;
                REQ_OP    = nop;
                REQ_KEY   = nkey;
                REQ_EXP   = nexp;
            end
            if (op && k == L + 1) begin
                m_rsp_data  = res_val;
                m_rsp_empty = ~res_val[0];
                if (res_val != exp_val) m_err = 1'b1;
            end
            if (k > total)     exp_cmd = IDLE_CMD;
            else if (op)       exp_cmd = (k <= H) ? POP_CMD : IDLE_CMD;
            else               exp_cmd = (k <= P) ? (IDLE_CMD | {24'b0, key}) : IDLE_CMD;
            chk("cmd", PORT_KEYPRT_CMD, exp_cmd);
            chk("busy", 32'(BUSY), 32'(k <= total));
            chk("ready", 32'(REQ_READY), 32'(k > total));
            chk("rsp_valid", 32'(RSP_VALID), 32'(op && k == L + 1));
            chk("rsp_data", RSP_DATA, m_rsp_data);
            if (op && k == L + 1) chk("rsp_empty", 32'(RSP_EMPTY), 32'(m_rsp_empty));
            chk_err();
            PORT_KEYPRT_RES = (op && k == L) ? res_val : $urandom();
        end
    endtask

    task automatic issue(input logic op, input logic [7:0] key, input logic [31:0] res_val,
                         input logic [31:0] exp_val, input logic hold, input logic nop,
                         input logic [7:0] nkey, input logic [31:0] nexp);
        REQ_VALID = 1'b1;
        REQ_OP    = op;
        REQ_KEY   = key;
        REQ_EXP   = exp_val;
        run_op(op, key, res_val, exp_val, hold, nop, nkey, nexp);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_cmd"}, PORT_KEYPRT_CMD, IDLE_CMD);
        chk({tag, "_ready"}, 32'(REQ_READY), 32'd1);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    endtask

    // Reset lands ncyc cycles into an operation; nothing may emerge until release.
    task automatic reset_mid(input logic op, input logic [7:0] key, input int ncyc);
        REQ_VALID = 1'b1;
        REQ_OP    = op;
        REQ_KEY   = key;
        REQ_EXP   = $urandom();
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge CLK);
            REQ_VALID = 1'b0;
            chk("mid_cmd", PORT_KEYPRT_CMD, op ? POP_CMD : (IDLE_CMD | {24'b0, key}));
            PORT_KEYPRT_RES = $urandom();
        end
        #2 RES = 1'b1;
        m_rsp_data  = '0;
        m_rsp_empty = 1'b0;
        m_err       = 1'b0;
        #1;
        chk("rst_cmd", PORT_KEYPRT_CMD, 32'h0);
        chk("rst_ready", 32'(REQ_READY), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_rsp_data", RSP_DATA, 32'h0);
        chk_err();
        for (int k = 0; k < L + 3; k++) begin
            @(negedge CLK);
            chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
            chk("rst_hold_cmd", PORT_KEYPRT_CMD, 32'h0);
            PORT_KEYPRT_RES = $urandom();
        end
        RES = 1'b0;
        @(negedge CLK);
        check_idle("after_rst");
        chk("after_rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    endtask

    initial begin
        RES             = 1'b1;
        REQ_VALID       = 1'b0;
        REQ_OP          = 1'b0;
        REQ_KEY         = 8'h00;
        REQ_EXP         = 32'h0;
        PORT_KEYPRT_RES = 32'h0;
        m_rsp_data      = '0;
        m_rsp_empty     = 1'b0;
        m_err           = 1'b0;

        repeat (2) @(negedge CLK);
        chk("reset_cmd", PORT_KEYPRT_CMD, 32'h0);
        chk("reset_ready", 32'(REQ_READY), 32'd0);
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("reset_rsp_data", RSP_DATA, 32'h0);
        chk("reset_rsp_empty", 32'(RSP_EMPTY), 32'd0);
        chk_err();
        RES = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check_idle("post_reset");
            PORT_KEYPRT_RES = $urandom();
        end

        issue(1'b0, 8'h9B, 32'h0, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        issue(1'b1, 8'h55, 32'h8000_2C01, 32'h8000_2C01, 1'b0, 1'b0, 8'h00, 32'h0);
        issue(1'b1, 8'hAA, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 8'h00, 32'h0);

        issue(1'b0, 8'h97, 32'h0, 32'h0, 1'b1, 1'b0, 8'h8E, 32'h0);
        run_op(1'b0, 8'h8E, 32'h0, 32'h0, 1'b1, 1'b1, 8'h3C, 32'h8000_4401);
        run_op(1'b1, 8'h3C, 32'h8000_4401, 32'h8000_4401, 1'b0, 1'b0, 8'h00, 32'h0);

        issue(1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);

        issue(1'b1, 8'h00, 32'h8000_3001, 32'h8000_3001, 1'b0, 1'b0, 8'h00, 32'h0);
        issue(1'b1, 8'h00, 32'h8000_0C01, 32'h8000_0001, 1'b0, 1'b0, 8'h00, 32'h0);
        issue(1'b1, 8'h00, 32'h8000_1201, 32'h8000_1201, 1'b0, 1'b0, 8'h00, 32'h0);

        for (int i = 0; i < NR; i++) begin
            r_op[i]   = 1'($urandom_range(0, 1));
            r_key[i]  = (i == 3) ? 8'h00 : 8'($urandom());
            r_res[i]  = $urandom();
            r_exp[i]  = ($urandom_range(0, 1) == 1) ? r_res[i] : $urandom();
            r_hold[i] = (i < NR - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        for (int i = 0; i < NR; i++) begin
            if (i < NR - 1)
                issue(r_op[i], r_key[i], r_res[i], r_exp[i], r_hold[i],
                      r_op[i+1], r_key[i+1], r_exp[i+1]);
            else
                issue(r_op[i], r_key[i], r_res[i], r_exp[i], 1'b0, 1'b0, 8'h00, 32'h0);
        end

        reset_mid(1'b0, 8'h93, 3);
        reset_mid(1'b1, 8'h00, 2);
        issue(1'b1, 8'h00, 32'h8000_2C00, 32'h8000_2C00, 1'b0, 1'b0, 8'h00, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
